id_scoreboard: RTL and testbench

ID_SCOREBOARD -- requirements
Module: id_scoreboard

---
 rtl/id_scoreboard_if.sv | 26 ++
 rtl/id_scoreboard.sv | 54 +++++
 tb/tb_id_scoreboard.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/id_scoreboard_if.sv
// id_scoreboard_if: issue request, source operands and hazard status between decode and scoreboard
interface id_scoreboard_if #(
   parameter int AW = 5,
   parameter int CW = 4
);
   logic          issue_valid;
   logic          issue_we;
   logic [AW-1:0] issue_rd;
   logic [CW-1:0] issue_lat;
   logic          use_rs;
   logic          use_rt;
   logic [AW-1:0] src_rs;
   logic [AW-1:0] src_rt;
   logic          flush;
   logic          stall;
   logic [AW:0]   pending_cnt;
   logic [31:0]   stall_cycles;
   modport master (
      output issue_valid, issue_we, issue_rd, issue_lat, use_rs, use_rt, src_rs, src_rt, flush,
      input  stall, pending_cnt, stall_cycles
   );
   modport slave (
      input  issue_valid, issue_we, issue_rd, issue_lat, use_rs, use_rt, src_rs, src_rt, flush,
      output stall, pending_cnt, stall_cycles
   );
endinterface

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register latency countdown RAW hazard detector; ID_SCOREBOARD_STATS_EN adds a stall-cycle counter
module id_scoreboard #(
   parameter int NREG    = 32,
   parameter int AW      = 5,
   parameter int MAX_LAT = 3,
   parameter int CW      = 4
) (
   input logic           clk,
   input logic           rst_n,
   id_scoreboard_if.slave sb
);
   logic [CW-1:0] cnt_q [NREG];
   logic [CW-1:0] cnt_d [NREG];
   logic [AW:0]   pending_cnt_q, pending_cnt_d;
   logic [CW-1:0] lat_sat;
   logic          hit_rs, hit_rt, stall, accept, load;
   always_comb begin
      hit_rs = sb.use_rs && sb.src_rs != '0 && cnt_q[sb.src_rs] != '0;
      hit_rt = sb.use_rt && sb.src_rt != '0 && cnt_q[sb.src_rt] != '0;
      stall = sb.issue_valid && !sb.flush && (hit_rs || hit_rt);
      accept = sb.issue_valid && !stall && !sb.flush;
      load = accept && sb.issue_we && sb.issue_rd != '0 && sb.issue_lat != '0;
      lat_sat = sb.issue_lat > CW'(MAX_LAT) ? CW'(MAX_LAT) : sb.issue_lat;
      pending_cnt_d = '0;
      for (int r = 0; r < NREG; r++) begin
         // a fresh issue overrides the decrement, even when its latency is shorter (WAW)
         cnt_d[r] = (sb.flush || r == 0) ? '0 :
                    (load && sb.issue_rd == AW'(r)) ? lat_sat :
                    (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
         pending_cnt_d = pending_cnt_d + (AW+1)'(cnt_d[r] != '0);
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt_q <= '{default: '0};
         pending_cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         pending_cnt_q <= pending_cnt_d;
      end
   assign sb.stall = stall;
   assign sb.pending_cnt = pending_cnt_q;
`ifdef ID_SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   always_comb
      stall_cycles_d = (stall && stall_cycles_q != '1) ? stall_cycles_q + 32'd1 : stall_cycles_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) stall_cycles_q <= '0;
      else stall_cycles_q <= stall_cycles_d;
   assign sb.stall_cycles = stall_cycles_q;
`else
   assign sb.stall_cycles = '0;
`endif
endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: randomized and directed checks against a ready-time model of the scoreboard
module tb_id_scoreboard;
   localparam int MAX_LAT = 3;
`ifdef ID_SCOREBOARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   id_scoreboard_if #(.AW(5), .CW(4)) sb ();
   id_scoreboard #(.NREG(32), .AW(5), .MAX_LAT(MAX_LAT), .CW(4)) dut (.clk(clk), .rst_n(rst_n), .sb(sb));
   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask
   // model: each register becomes readable at an absolute cycle number
   longint ready_at [32];
   longint cyc = 0;
   longint m_sc = 0;
   function automatic bit busy(input logic [4:0] r);
      return r != 0 && ready_at[r] > cyc;
   endfunction
   function automatic int m_pending();
      int n = 0;
      for (int r = 1; r < 32; r++) if (ready_at[r] > cyc) n++;
      return n;
   endfunction
   always @(negedge clk) begin
      bit es;
      int l;
      if (!rst_n) begin
         for (int r = 0; r < 32; r++) ready_at[r] = 0;
         m_sc = 0;
         chk("rst_stall", sb.stall, 0);
         chk("rst_pending", sb.pending_cnt, 0);
         chk("rst_stall_cycles", sb.stall_cycles, 0);
      end else begin
         es = sb.issue_valid && !sb.flush &&
              ((sb.use_rs && busy(sb.src_rs)) || (sb.use_rt && busy(sb.src_rt)));
         chk("stall", sb.stall, es);
         chk("pending_cnt", sb.pending_cnt, m_pending());
         chk("stall_cycles", sb.stall_cycles, STATS ? m_sc : 0);
         l = sb.issue_lat > MAX_LAT ? MAX_LAT : int'(sb.issue_lat);
         if (sb.flush)
            for (int r = 0; r < 32; r++) ready_at[r] = 0;
         else if (sb.issue_valid && !es && sb.issue_we && sb.issue_rd != 0 && sb.issue_lat != 0)
            ready_at[sb.issue_rd] = cyc + 1 + l;
         if (es && m_sc != 64'hFFFF_FFFF) m_sc++;
      end
      cyc++;
   end
   task automatic drive(input bit v, input bit we, input logic [4:0] rd, input logic [3:0] lat,
                        input bit urs, input logic [4:0] rs, input bit urt, input logic [4:0] rt,
                        input bit fl);
      @(posedge clk);
      #1;
      sb.issue_valid = v; sb.issue_we = we; sb.issue_rd = rd; sb.issue_lat = lat;
      sb.use_rs = urs; sb.src_rs = rs; sb.use_rt = urt; sb.src_rt = rt; sb.flush = fl;
      #1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      chk("reset_stall_lit", sb.stall, 0);
      chk("reset_pending_lit", sb.pending_cnt, 0);
      rst_n = 1'b1;
      idle(1);
      // load-use
      drive(1, 1, 8, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 8, 0, 0, 0);
      chk("lu_stall", sb.stall, 1);
      chk("lu_pending", sb.pending_cnt, 1);
      drive(1, 0, 0, 0, 1, 8, 0, 0, 0);
      chk("lu_release", sb.stall, 0);
      chk("lu_pending0", sb.pending_cnt, 0);
      idle(4);
      // long latency on rt
      drive(1, 1, 5, 3, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0, 0, 1, 5, 0);
         chk("long_stall", sb.stall, 1);
      end
      drive(1, 0, 0, 0, 0, 0, 1, 5, 0);
      chk("long_release", sb.stall, 0);
      idle(4);
      // register 0 never tracked
      drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
      chk("r0_stall", sb.stall, 0);
      chk("r0_pending", sb.pending_cnt, 0);
      idle(4);
      // saturation then WAW with a shorter latency
      drive(1, 1, 9, 15, 0, 0, 0, 0, 0);
      drive(1, 1, 9, 1, 0, 0, 0, 0, 0);
      chk("sat_pending", sb.pending_cnt, 1);
      chk("sat_nostall", sb.stall, 0);
      drive(1, 0, 0, 0, 1, 9, 0, 0, 0);
      chk("waw_stall", sb.stall, 1);
      drive(1, 0, 0, 0, 1, 9, 0, 0, 0);
      chk("waw_release", sb.stall, 0);
      idle(4);
      // flush kills stall and tracking, ignores its own issue
      drive(1, 1, 4, 3, 0, 0, 0, 0, 0);
      drive(1, 1, 7, 2, 1, 4, 0, 0, 1);
      chk("flush_stall", sb.stall, 0);
      drive(1, 0, 0, 0, 1, 4, 1, 7, 0);
      chk("flush_pending", sb.pending_cnt, 0);
      chk("flush_after_stall", sb.stall, 0);
      idle(2);
      // asynchronous reset between edges while stalled
      drive(1, 1, 6, 3, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 6, 0, 0, 0);
      chk("ar_stall", sb.stall, 1);
      rst_n = 1'b0;
      #1;
      chk("ar_stall_drop", sb.stall, 0);
      chk("ar_pending", sb.pending_cnt, 0);
      chk("ar_stall_cycles", sb.stall_cycles, 0);
      idle(2);
      rst_n = 1'b1;
      // randomized traffic, biased towards a few registers to create hazards
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] rd, rs, rt;
         rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
         rs = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
         rt = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rd, 4'($urandom),
               1'($urandom), rs, 1'($urandom), rt, $urandom_range(0, 29) == 0);
      end
      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
